// File: rtl/lfsr_stream_decoder.sv
// Receive side of the LFSR byte-stream cipher: recovers the LFSR state from a known-plaintext preamble,
// then regenerates the keystream to emit plaintext. Optional CHK-phase keystream check: LFSR_DEC_PRECHECK_EN.
module lfsr_stream_decoder #(
  parameter logic [7:0]  PRE_CHAR = 8'h5F,
  parameter int unsigned PRE_LEN  = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [31:0] key_state,
  output logic        locked,
  output logic        sync_err
);

  typedef enum logic [1:0] {IDLE, SYNC, CHK, RUN} state_e;

  localparam logic [3:0] PRE_LEN_C = 4'(PRE_LEN);

  // Eight LFSR steps unrolled; the low byte of the result is the keystream byte for the old state.
  function automatic logic [31:0] step8(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    for (int i = 0; i < 8; i++) r = {r[30:0], r[2] ^ r[5] ^ r[6] ^ r[12] ^ r[30]};
    return r;
  endfunction

  state_e      state_q, state_d;
  logic [31:0] key_q, key_d;
  logic [3:0]  count_q, count_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_last_q, out_last_d;
  logic        locked_q, locked_d;
  logic        sync_err_q, sync_err_d;

  logic [31:0] next_key;
  logic [7:0]  ks;
  logic [3:0]  count_inc;
  logic        accept;

  assign next_key  = step8(key_q);
  assign ks        = next_key[7:0];
  assign count_inc = (count_q < PRE_LEN_C) ? count_q + 4'd1 : count_q;

  always_comb begin
    in_ready = 1'b0;
    if (!start) begin
      unique case (state_q)
        SYNC, CHK: in_ready = 1'b1;
        RUN:       in_ready = !out_valid_q || out_ready;
        default:   in_ready = 1'b0;
      endcase
    end
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case can infer a latch.
    state_d     = state_q;
    key_d       = key_q;
    count_d     = count_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    locked_d    = locked_q;
    sync_err_d  = sync_err_q;

    if (out_valid_q && out_ready) out_valid_d = 1'b0;

    if (start) begin
      // A restart drops any pending output and the byte offered this cycle.
      state_d     = SYNC;
      key_d       = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      locked_d    = 1'b0;
      sync_err_d  = 1'b0;
    end else if (accept) begin
      unique case (state_q)
        SYNC: begin
          key_d   = {key_q[23:0], in_data ^ PRE_CHAR};
          count_d = count_inc;
          if (count_q == 4'd3) begin
            locked_d = 1'b1;
            state_d  = (PRE_LEN > 4) ? CHK : RUN;
          end
          if (in_last) begin
            state_d    = IDLE;
            locked_d   = 1'b0;
            sync_err_d = 1'b1;
          end
        end
        CHK: begin
          key_d   = next_key;
          count_d = count_inc;
          if (count_inc == PRE_LEN_C) state_d = RUN;
`ifdef LFSR_DEC_PRECHECK_EN
          if ((in_data ^ ks) != PRE_CHAR) begin
            state_d    = IDLE;
            locked_d   = 1'b0;
            sync_err_d = 1'b1;
          end
`endif
          if (in_last) begin
            state_d    = IDLE;
            locked_d   = 1'b0;
            sync_err_d = 1'b1;
          end
        end
        RUN: begin
          key_d       = next_key;
          out_data_d  = in_data ^ ks;
          out_valid_d = 1'b1;
          out_last_d  = in_last;
          if (in_last) begin
            state_d  = IDLE;
            locked_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      key_q       <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      locked_q    <= 1'b0;
      sync_err_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
      state_q     <= state_d;
      key_q       <= key_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      locked_q    <= locked_d;
      sync_err_q  <= sync_err_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign key_state = key_q;
  assign locked    = locked_q;
  assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_lfsr_stream_decoder.sv
// Scoreboard bench for lfsr_stream_decoder: a reference encoder produces ciphertext, expected plaintext
// is queued on send and compared when the decoder hands a byte to the sink.
module tb_lfsr_stream_decoder;

  localparam logic [7:0] PRE = 8'h5F;
  localparam int         PL  = 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic        out_ready = 1'b1;
  logic [31:0] key_state;
  logic        locked;
  logic        sync_err;

  lfsr_stream_decoder #(.PRE_CHAR(PRE), .PRE_LEN(PL)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
    .key_state(key_state), .locked(locked), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference LFSR: one new bit per step, shifted in at the bottom.
  function automatic logic [31:0] ref_step8(input logic [31:0] s);
    logic [31:0] v;
    logic        fb;
    v = s;
    repeat (8) begin
      fb = v[30] ^ v[12] ^ v[6] ^ v[5] ^ v[2];
      v  = (v << 1) | {31'b0, fb};
    end
    return v;
  endfunction

  // Reference encoder: the first four bytes carry the seed masked by plaintext, the rest use the keystream.
  logic [31:0] enc_seed, enc_s;
  int          enc_idx;

  task automatic enc_start(input logic [31:0] seed);
    enc_seed = seed;
    enc_s    = seed;
    enc_idx  = 0;
  endtask

  task automatic encode(input logic [7:0] p, output logic [7:0] c);
    logic [31:0] nxt;
    if (enc_idx < 4) begin
      c = p ^ enc_seed[31 - 8*enc_idx -: 8];
    end else begin
      nxt   = ref_step8(enc_s);
      c     = p ^ nxt[7:0];
      enc_s = nxt;
    end
    enc_idx++;
  endtask

  logic [8:0] sb[$];

  always @(negedge clk) begin
    logic [8:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("unexpected_out", sb.size(), 1);
      else begin
        e = sb.pop_front();
        check("out_data", out_data, e[7:0]);
        check("out_last", out_last, e[8]);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l);
    int waited;
    waited   = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_pre(input logic [7:0] p, input logic l);
    logic [7:0] c;
    encode(p, c);
    send_byte(c, l);
  endtask

  task automatic send_pay(input logic [7:0] p, input logic l);
    logic [7:0] c;
    encode(p, c);
    sb.push_back({l, p});
    send_byte(c, l);
  endtask

  task automatic drain();
    int waited;
    waited = 0;
    while ((sb.size() != 0 || out_valid) && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("drain_sb_empty", sb.size(), 0);
  endtask

  task automatic preamble(input logic [31:0] seed);
    enc_start(seed);
    pulse_start();
    for (int i = 0; i < PL; i++) send_pre(PRE, 1'b0);
  endtask

  logic [7:0]  hello [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
  logic [7:0]  dead  [4] = '{8'h81, 8'hF2, 8'hE1, 8'hB0};
  logic [31:0] seed;
  logic [7:0]  c;
  bit          done;

  initial begin
    // Reset state
    #12;
    check("rst_key", key_state, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_locked", locked, 0);
    check("rst_sync_err", sync_err, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", in_ready, 0);

    // IDLE ignores bytes without start
    in_data = 8'hAA; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("idle_key_unchanged", key_state, 0);

    // Recover DEADBEEF, then decode HELLO
    enc_start(32'hDEADBEEF);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      encode(PRE, c);
      check("dead_cipher", c, dead[i]);
      send_byte(dead[i], 1'b0);
    end
    check("dead_key", key_state, 32'hDEADBEEF);
    check("dead_locked", locked, 1);
    check("dead_no_out", out_valid, 0);
    for (int i = 4; i < PL; i++) send_pre(PRE, 1'b0);
    check("chk_key", key_state, enc_s);
    check("chk_no_out", out_valid, 0);
    for (int i = 0; i < 5; i++) send_pay(hello[i], i == 4);
    drain();
    check("hello_unlocked", locked, 0);
    check("hello_idle", in_ready, 0);

    // All-zero state: keystream is zero
    preamble(32'h0);
    check("zero_key", key_state, 0);
    send_pay(8'h41, 1'b1);
    drain();

    // Backpressure: hold out_ready low in RUN
    seed = $urandom;
    preamble(seed);
    out_ready = 1'b0;
    send_pay(8'h10, 1'b0);
    encode(8'h11, c);
    in_data = c; in_valid = 1'b1; in_last = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_data", out_data, 8'h10);
      check("bp_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    sb.push_back({1'b0, 8'h11});
    send_byte(c, 1'b0);
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) send_pay(8'(8'h20 + i), i == 11);
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // start drops a pending output
    preamble($urandom);
    out_ready = 1'b0;
    send_pay(8'h77, 1'b0);
    check("pend_valid", out_valid, 1);
    sb.delete();
    pulse_start();
    check("start_drops_out", out_valid, 0);
    check("start_unlocks", locked, 0);
    out_ready = 1'b1;

    // Truncated preamble
    enc_start(32'h12345678);
    pulse_start();
    send_pre(PRE, 1'b0);
    send_pre(PRE, 1'b0);
    send_pre(PRE, 1'b1);
    check("trunc_sync_err", sync_err, 1);
    check("trunc_locked", locked, 0);
    check("trunc_idle", in_ready, 0);
    pulse_start();
    check("restart_clears_err", sync_err, 0);

    // Corrupted 5th preamble byte
    enc_start(32'hCAFEF00D);
    pulse_start();
    for (int i = 0; i < 4; i++) send_pre(PRE, 1'b0);
    encode(PRE, c);
    send_byte(c ^ 8'h01, 1'b0);
`ifdef LFSR_DEC_PRECHECK_EN
    check("corrupt_sync_err", sync_err, 1);
    check("corrupt_locked", locked, 0);
    check("corrupt_idle", in_ready, 0);
`else
    check("corrupt_locked", locked, 1);
    check("corrupt_no_err", sync_err, 0);
    for (int i = 5; i < PL; i++) send_pre(PRE, 1'b0);
    send_pay(8'h4F, 1'b0);
    send_pay(8'h4B, 1'b1);
    drain();
`endif

    // Reset mid-message
    preamble(32'h0BADC0DE);
    out_ready = 1'b0;
    send_pay(8'h33, 1'b0);
    sb.delete();
    rst_n = 1'b0;
    #2;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_key", key_state, 0);
    check("mid_rst_locked", locked, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
